csa_serial_accumulator: RTL and testbench

Multi-operand accumulator that sums a run of N unsigned operands in carry-save form and then resolves the redundant sum with an iterative carry-propagate phase. It is the parametrised, sequential successor to the team's fixed 4-bit three-input carry-save adder. It sits between a streaming operand source (valid/ready) and a result consumer (valid/ready). Operand width and maximum run length are parameters. The result register is sized so that no run can overflow it.

---
 rtl/csa_serial_accumulator.sv | 120 ++++++++++++
 tb/tb_csa_serial_accumulator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/csa_serial_accumulator.sv
// Sequential multi-operand adder: 3:2 carry-save accumulation of a run
// of operands, then an iterative carry-propagate resolve of S/C.
module csa_serial_accumulator #(
  parameter  int WIDTH   = 4,
  parameter  int COUNT_W = 3,
  localparam int ACC_W   = WIDTH + COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_ops,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [ACC_W-1:0]   out_sum,
  input  logic               out_ready,
  output logic               busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCUM   = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [COUNT_W-1:0] REM_LAST = COUNT_W'(1);

  logic [1:0]         r_state;
  logic [ACC_W-1:0]   r_s;
  logic [ACC_W-1:0]   r_c;
  logic [COUNT_W-1:0] r_rem;
  logic [ACC_W-1:0]   r_out_sum;

  logic [ACC_W-1:0]   w_x;
  logic [ACC_W-1:0]   w_maj;
  logic [ACC_W-1:0]   w_csa_s;
  logic [ACC_W-1:0]   w_csa_c;
  logic [ACC_W-1:0]   w_res_s;
  logic [ACC_W-1:0]   w_res_c;
  logic               w_take;
  logic               w_give;

  assign w_x     = {{COUNT_W{1'b0}}, in_data};
  assign w_maj   = (r_s & r_c) | (r_s & w_x) | (r_c & w_x);
  assign w_csa_s = r_s ^ r_c ^ w_x;
  assign w_csa_c = {w_maj[ACC_W-2:0], 1'b0};

  // One ripple step per cycle: the carry vector shifts left until empty.
  assign w_res_s = r_s ^ r_c;
  assign w_res_c = {w_res_and(r_s, r_c), 1'b0};

  function automatic logic [ACC_W-2:0] w_res_and(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b
  );
    logic [ACC_W-1:0] t;
    t = a & b;
    return t[ACC_W-2:0];
  endfunction

  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_sum   = r_out_sum;

  assign w_take = in_valid & in_ready;
  assign w_give = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_s       <= '0;
      r_c       <= '0;
      r_rem     <= '0;
      r_out_sum <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_s   <= '0;
            r_c   <= '0;
            r_rem <= num_ops;
            if (num_ops == '0) begin
              r_out_sum <= '0;
              r_state   <= ST_DONE;
            end else begin
              r_state <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (w_take) begin
            r_s   <= w_csa_s;
            r_c   <= w_csa_c;
            r_rem <= r_rem - REM_LAST;
            if (r_rem == REM_LAST) begin
              r_state <= ST_RESOLVE;
            end
          end
        end
        ST_RESOLVE: begin
          if (r_c == '0) begin
            r_out_sum <= r_s;
            r_state   <= ST_DONE;
          end else begin
            r_s <= w_res_s;
            r_c <= w_res_c;
          end
        end
        ST_DONE: begin
          if (w_give) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_serial_accumulator.sv
// Directed bench for csa_serial_accumulator (WIDTH=4, COUNT_W=3).
module tb_csa_serial_accumulator;

  localparam int WIDTH   = 4;
  localparam int COUNT_W = 3;
  localparam int ACC_W   = WIDTH + COUNT_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [COUNT_W-1:0] num_ops;
  logic               in_valid;
  logic [WIDTH-1:0]   in_data;
  logic               in_ready;
  logic               out_valid;
  logic [ACC_W-1:0]   out_sum;
  logic               out_ready;
  logic               busy;

  int n_pass  = 0;
  int n_total = 0;

  csa_serial_accumulator #(
    .WIDTH  (WIDTH),
    .COUNT_W(COUNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_ops  (num_ops),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_sum  (out_sum),
    .out_ready(out_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic start_run(input int n);
    start   = 1'b1;
    num_ops = COUNT_W'(n);
    step();
    start   = 1'b0;
    num_ops = '0;
  endtask

  task automatic feed(input int x);
    in_valid = 1'b1;
    in_data  = WIDTH'(x);
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Counts cycles from RESOLVE entry until out_valid, bounded.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    chk("wait_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_sum"}, 32'(out_sum), 32'd0);
  endtask

  initial begin
    int cyc;
    rst       = 1'b1;
    start     = 1'b0;
    num_ops   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    idle_checks("reset");

    // Basic run: 11 + 13 + 6 = 30
    start_run(3);
    chk("basic_in_ready", 32'(in_ready), 32'd1);
    chk("basic_busy", 32'(busy), 32'd1);
    feed(11);
    feed(13);
    feed(6);
    chk("basic_ready_drop", 32'(in_ready), 32'd0);
    wait_valid(cyc);
    chk("basic_sum", 32'(out_sum), 32'd30);
    chk("basic_res_len", 32'(cyc <= ACC_W + 1), 32'd1);
    step();
    chk("basic_pulse", 32'(out_valid), 32'd0);
    chk("basic_idle", 32'(busy), 32'd0);

    // Maximum run: 7 * 15 = 105
    start_run(7);
    for (int i = 0; i < 7; i++) feed(15);
    wait_valid(cyc);
    chk("max_sum", 32'(out_sum), 32'd105);
    chk("max_res_len", 32'(cyc <= ACC_W + 1), 32'd1);
    step();

    // N=0: result in the cycle after start
    start_run(0);
    chk("n0_valid", 32'(out_valid), 32'd1);
    chk("n0_sum", 32'(out_sum), 32'd0);
    chk("n0_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("n0_done", 32'(out_valid), 32'd0);

    start_run(1);
    feed(0);
    wait_valid(cyc);
    chk("n1_zero", 32'(out_sum), 32'd0);
    step();

    start_run(1);
    feed(15);
    wait_valid(cyc);
    chk("n1_max", 32'(out_sum), 32'd15);
    step();

    // Flow control with input gaps and output backpressure
    start_run(3);
    feed(1);
    step();
    step();
    step();
    chk("gap_still_accum", 32'(in_ready), 32'd1);
    feed(2);
    step();
    out_ready = 1'b0;
    feed(1);
    wait_valid(cyc);
    chk("flow_sum", 32'(out_sum), 32'd4);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(out_sum), 32'd4);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release", 32'(out_valid), 32'd0);
    chk("bp_idle", 32'(busy), 32'd0);
    step();
    chk("start_ignored", 32'(busy), 32'd0);

    // Reset mid-ACCUM
    start_run(5);
    feed(3);
    feed(4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_checks("rst_accum");
    start_run(1);
    feed(5);
    wait_valid(cyc);
    chk("after_rst_accum", 32'(out_sum), 32'd5);
    step();

    // Reset mid-RESOLVE
    start_run(2);
    feed(7);
    feed(9);
    chk("in_resolve", 32'(busy & ~out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_checks("rst_resolve");
    start_run(1);
    feed(5);
    wait_valid(cyc);
    chk("after_rst_resolve", 32'(out_sum), 32'd5);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
